// File: rtl/inst_fetch_pkg.sv
// Shared widths, stall-bus bit positions and types for the instruction-fetch front end.
package inst_fetch_pkg;

    localparam int STALL_WD    = 6;
    localparam int STALL_PC    = 0;
    localparam int STALL_IF    = 1;
    localparam int STALL_ID    = 2;
    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;

    typedef logic [STALL_WD-1:0] stall_bus_t;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    typedef enum logic [0:0] {
        HB_PASS = 1'b0,
        HB_HOLD = 1'b1
    } hold_state_e;

    // Sequential fetch address; wraps naturally at 2^32.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction SRAM port bundle: fetch side is master, memory side is slave.
interface inst_fetch_if;

    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        output inst_sram_rdata
    );

endinterface

// File: rtl/inst_fetch_hold_buf.sv
// Instruction hold buffer: freezes the instruction seen by decode while decode is stalled,
// compensating for the one-cycle synchronous SRAM read.
module inst_hold_buf
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [31:0] rdata,
    output logic [31:0] inst
);

    hold_state_e state_q;
    hold_state_e state_d;
    logic [31:0] hold_q;
    logic [31:0] hold_d;

    // State and buffer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HB_PASS;
            hold_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next state, buffer capture and the instruction presented to decode.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        inst    = rdata;
        case (state_q)
            HB_PASS: begin
                inst = rdata;
                if (hold) begin
                    hold_d  = rdata;
                    state_d = HB_HOLD;
                end else begin
                    state_d = HB_PASS;
                end
            end
            HB_HOLD: begin
                inst = hold_q;
                if (!hold) begin
                    state_d = HB_PASS;
                end else begin
                    state_d = HB_HOLD;
                end
            end
            default: begin
                inst    = rdata;
                state_d = HB_PASS;
            end
        endcase
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC register, pending-branch capture across PC stalls,
// instruction SRAM request and the decode-side hold buffer.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  stall_bus_t             stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic [31:0]            id_inst,
    inst_fetch_if.master           sram
);

    localparam logic [31:0] PC_RESET_VAL = RESET_PC - 32'd4;

    br_bus_t     br_s;
    logic        stall_pc_s;
    logic        stall_id_s;
    logic        unused_stall_s;
    logic [31:0] next_pc_s;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        ce_q;
    logic        ce_d;
    logic        pend_valid_q;
    logic        pend_valid_d;
    logic [31:0] pend_addr_q;
    logic [31:0] pend_addr_d;

    assign br_s       = br_s_cast(br_bus);
    assign stall_pc_s = stall[STALL_PC];
    assign stall_id_s = stall[STALL_ID];
    // The IF bit only ever accompanies a PC stall, so PC stall alone governs fetch.
    assign unused_stall_s = ^{stall[STALL_WD-1:3], stall[STALL_IF]};

    function automatic br_bus_t br_s_cast(input logic [BR_WD-1:0] raw);
        return br_bus_t'(raw);
    endfunction

    // Next fetch address: live redirect beats a parked one, else sequential.
    always_comb begin
        next_pc_s = pc_incr(pc_q);
        if (br_s.br_e) begin
            next_pc_s = br_s.br_addr;
        end else if (pend_valid_q) begin
            next_pc_s = pend_addr_q;
        end else begin
            next_pc_s = pc_incr(pc_q);
        end
    end

    // PC advance and pending-branch capture while the PC is stalled.
    always_comb begin
        pc_d         = pc_q;
        ce_d         = ce_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        if (!stall_pc_s) begin
            pc_d         = next_pc_s;
            ce_d         = 1'b1;
            pend_valid_d = 1'b0;
        end else if (br_s.br_e) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = br_s.br_addr;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= PC_RESET_VAL;
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'h0000_0000;
        end else begin
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign if_to_id_bus         = {ce_q, pc_q};
    assign sram.inst_sram_en    = ce_q;
    assign sram.inst_sram_wen   = 4'b0000;
    assign sram.inst_sram_addr  = pc_q;
    assign sram.inst_sram_wdata = 32'h0000_0000;

    inst_hold_buf u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .hold  (stall_id_s),
        .rdata (sram.inst_sram_rdata),
        .inst  (id_inst)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural one-cycle-latency instruction SRAM.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic [31:0] id_inst;
    logic [31:0] rdata_r = 32'h0000_0000;
    int n_vec = 0;
    int n_err = 0;

    inst_fetch_if sram_if ();

    inst_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_bus       (br_bus),
        .if_to_id_bus (if_to_id_bus),
        .id_inst      (id_inst),
        .sram         (sram_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    always @(posedge clk) begin
        if (sram_if.inst_sram_en) rdata_r <= mem_f(sram_if.inst_sram_addr);
    end
    assign sram_if.inst_sram_rdata = rdata_r;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 6'b0; br_bus = 33'b0;
        repeat (3) tick();
        n_vec++; if (if_to_id_bus !== {1'b0, 32'hBFBF_FFFC}) begin n_err++; $display("FAIL reset_bus got %h want %h", if_to_id_bus, {1'b0, 32'hBFBF_FFFC}); end
        n_vec++; if (sram_if.inst_sram_en !== 1'b0) begin n_err++; $display("FAIL reset_en got %b want 0", sram_if.inst_sram_en); end
        n_vec++; if ({sram_if.inst_sram_wen, sram_if.inst_sram_wdata} !== 36'h0) begin n_err++; $display("FAIL reset_wr got %h/%h want 0/0", sram_if.inst_sram_wen, sram_if.inst_sram_wdata); end
        n_vec++; if (id_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h want 0", id_inst); end
    endtask

    task automatic test_reset_release();
        rst = 1'b0;
        tick();
        n_vec++; if (if_to_id_bus !== {1'b1, 32'hBFC0_0000}) begin n_err++; $display("FAIL release_bus got %h want %h", if_to_id_bus, {1'b1, 32'hBFC0_0000}); end
        n_vec++; if (sram_if.inst_sram_en !== 1'b1) begin n_err++; $display("FAIL release_en got %b want 1", sram_if.inst_sram_en); end
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'hBFC0_0004) begin n_err++; $display("FAIL release_addr1 got %h want BFC00004", sram_if.inst_sram_addr); end
        n_vec++; if (id_inst !== mem_f(32'hBFC0_0000)) begin n_err++; $display("FAIL release_inst got %h want %h", id_inst, mem_f(32'hBFC0_0000)); end
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'hBFC0_0008) begin n_err++; $display("FAIL release_addr2 got %h want BFC00008", sram_if.inst_sram_addr); end
        repeat (2) tick();
    endtask

    task automatic test_stall_hold();
        stall = 6'b000111;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (sram_if.inst_sram_addr !== 32'hBFC0_0010) begin n_err++; $display("FAIL stall_addr[%0d] got %h want BFC00010", i, sram_if.inst_sram_addr); end
            n_vec++; if (id_inst !== mem_f(32'hBFC0_000C)) begin n_err++; $display("FAIL stall_inst[%0d] got %h want %h", i, id_inst, mem_f(32'hBFC0_000C)); end
        end
        stall = 6'b0;
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'hBFC0_0014) begin n_err++; $display("FAIL stall_rel_addr got %h want BFC00014", sram_if.inst_sram_addr); end
        n_vec++; if (id_inst !== mem_f(32'hBFC0_0010)) begin n_err++; $display("FAIL stall_rel_inst got %h want %h", id_inst, mem_f(32'hBFC0_0010)); end
    endtask

    task automatic test_branch();
        br_bus = {1'b1, 32'h8000_0100};
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'h8000_0100) begin n_err++; $display("FAIL br_addr got %h want 80000100", sram_if.inst_sram_addr); end
        br_bus = 33'b0;
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'h8000_0104) begin n_err++; $display("FAIL br_seq got %h want 80000104", sram_if.inst_sram_addr); end
        n_vec++; if (id_inst !== mem_f(32'h8000_0100)) begin n_err++; $display("FAIL br_inst got %h want %h", id_inst, mem_f(32'h8000_0100)); end
    endtask

    task automatic test_branch_stall();
        stall = 6'b000111; br_bus = {1'b1, 32'h8000_0200};
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++; if (sram_if.inst_sram_addr !== 32'h8000_0104) begin n_err++; $display("FAIL brst_hold[%0d] got %h want 80000104", i, sram_if.inst_sram_addr); end
        end
        br_bus = 33'b0; stall = 6'b0;
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'h8000_0200) begin n_err++; $display("FAIL brst_addr got %h want 80000200", sram_if.inst_sram_addr); end
        n_vec++; if (id_inst !== mem_f(32'h8000_0104)) begin n_err++; $display("FAIL brst_inst got %h want %h", id_inst, mem_f(32'h8000_0104)); end
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'h8000_0204) begin n_err++; $display("FAIL brst_seq got %h want 80000204", sram_if.inst_sram_addr); end
    endtask

    task automatic test_pending_overwrite();
        stall = 6'b000111; br_bus = {1'b1, 32'h8000_0300};
        tick();
        br_bus = {1'b1, 32'h8000_0400};
        tick();
        br_bus = 33'b0;
        tick();
        stall = 6'b0;
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'h8000_0400) begin n_err++; $display("FAIL pend_ovw got %h want 80000400", sram_if.inst_sram_addr); end
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'h8000_0404) begin n_err++; $display("FAIL pend_clr got %h want 80000404", sram_if.inst_sram_addr); end
    endtask

    task automatic test_ignored_bits();
        stall = 6'b111010;
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'h8000_0408) begin n_err++; $display("FAIL ign_bits got %h want 80000408", sram_if.inst_sram_addr); end
        stall = 6'b0;
    endtask

    task automatic test_wrap();
        br_bus = {1'b1, 32'hFFFF_FFFC};
        tick();
        br_bus = 33'b0;
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'h0000_0000) begin n_err++; $display("FAIL wrap got %h want 00000000", sram_if.inst_sram_addr); end
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'h0000_0004) begin n_err++; $display("FAIL wrap_seq got %h want 00000004", sram_if.inst_sram_addr); end
        n_vec++; if (id_inst !== mem_f(32'h0000_0000)) begin n_err++; $display("FAIL wrap_inst got %h want %h", id_inst, mem_f(32'h0000_0000)); end
    endtask

    task automatic test_reset_mid_op();
        stall = 6'b000111; br_bus = {1'b1, 32'h8000_0500};
        tick();
        br_bus = 33'b0; rst = 1'b1;
        tick();
        n_vec++; if (if_to_id_bus !== {1'b0, 32'hBFBF_FFFC}) begin n_err++; $display("FAIL mid_rst_bus got %h want %h", if_to_id_bus, {1'b0, 32'hBFBF_FFFC}); end
        n_vec++; if (id_inst !== mem_f(32'h0000_0004)) begin n_err++; $display("FAIL mid_rst_pass got %h want %h", id_inst, mem_f(32'h0000_0004)); end
        rst = 1'b0; stall = 6'b0;
        tick();
        n_vec++; if (if_to_id_bus !== {1'b1, 32'hBFC0_0000}) begin n_err++; $display("FAIL mid_rst_pc got %h want %h", if_to_id_bus, {1'b1, 32'hBFC0_0000}); end
        tick();
        n_vec++; if (sram_if.inst_sram_addr !== 32'hBFC0_0004) begin n_err++; $display("FAIL mid_rst_seq got %h want BFC00004", sram_if.inst_sram_addr); end
        n_vec++; if (id_inst !== mem_f(32'hBFC0_0000)) begin n_err++; $display("FAIL mid_rst_inst got %h want %h", id_inst, mem_f(32'hBFC0_0000)); end
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_stall_hold();
        test_branch();
        test_branch_stall();
        test_pending_overwrite();
        test_ignored_bits();
        test_wrap();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
